// File: rtl/half_pkg.sv
// Shared binary16 definitions for the half-precision datapath (multiplier and
// divider): field layout, bias, saturation constants and the divider FSM states.
// Build option: HALF_DIVIDE_ROUND_EN selects the 13-bit quotient used for
// round half-up in half_divide; without it the quotient is 12 bits and the
// fraction is truncated.
package half_pkg;

    typedef struct packed {
        logic       sign;
        logic [4:0] exp;
        logic [9:0] frac;
    } half_t;

    localparam int unsigned HALF_BIAS     = 15;
    localparam logic [4:0]  HALF_EXP_SAT  = 5'h1F;
    localparam logic [9:0]  HALF_FRAC_SAT = 10'h3FF;
    localparam logic [14:0] HALF_MAG_SAT  = {HALF_EXP_SAT, HALF_FRAC_SAT};

`ifdef HALF_DIVIDE_ROUND_EN
    localparam int unsigned HALF_QBITS = 13;
`else
    localparam int unsigned HALF_QBITS = 12;
`endif

    typedef enum logic [1:0] {IDLE, DIV, NORM} div_state_t;

endpackage

// File: rtl/half_mant_div.sv
// Restoring mantissa divider: one quotient bit per cycle, MSB first.
// Ports:
//   clk, rstn  clock, synchronous active-low reset
//   start_i    load operands and begin (ignored by caller while busy)
//   ma_i/mb_i  11-bit significands {1,frac}
//   q_o        QBITS-bit quotient, final one cycle after done_o
//   done_o     high during the cycle that produces the last quotient bit
module half_mant_div #(
    parameter int unsigned QBITS = 12
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start_i,
    input  logic [10:0]      ma_i,
    input  logic [10:0]      mb_i,
    output logic [QBITS-1:0] q_o,
    output logic             done_o
);

    localparam logic [3:0]       LAST = 4'(QBITS - 1);
    localparam logic [QBITS-1:0] QONE = {{(QBITS-1){1'b0}}, 1'b1};

    logic [12:0]      r_q;
    logic [10:0]      mb_q;
    logic [QBITS-1:0] q_q;
    logic [3:0]       cnt_q;
    logic             busy_q;

    logic             ge;
    logic [12:0]      r_d;
    logic [QBITS-1:0] q_d;

    assign ge  = (r_q >= {2'b00, mb_q});
    // The shift discards bit 12; the remainder stays below 2*mb so it never carries there.
    assign r_d = (ge ? (r_q - {2'b00, mb_q}) : r_q) << 1;
    assign q_d = q_q | (ge ? (QONE << (LAST - cnt_q)) : '0);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_q    <= '0;
            mb_q   <= '0;
            q_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start_i) begin
            r_q    <= {2'b00, ma_i};
            mb_q   <= mb_i;
            q_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            r_q   <= r_d;
            q_q   <= q_d;
            cnt_q <= cnt_q + 4'd1;
            if (cnt_q == LAST) busy_q <= 1'b0;
        end
    end

    assign q_o    = q_q;
    assign done_o = busy_q && (cnt_q == LAST);

endmodule

// File: rtl/half_divide.sv
// Iterative binary16 divider c = a / b with valid/ready input and a
// one-cycle out_valid pulse. Subnormal/zero results flush to zero, overflow
// saturates to magnitude 7FFF, exponent 1F inputs are treated as ordinary.
// Ports:
//   clk, rstn          clock, synchronous active-low reset
//   in_valid/in_ready  operand handshake; accept when both high
//   a, b               dividend, divisor (binary16)
//   out_valid          one-cycle pulse when c is updated
//   c                  quotient, held until the next result
//   div_zero           divisor magnitude was zero (qualified by out_valid)
// Build option: HALF_DIVIDE_ROUND_EN enables round half-up (13 quotient bits,
// latency 14); default build truncates (12 quotient bits, latency 13).
module half_divide
    import half_pkg::*;
#(
    parameter int unsigned BIAS  = HALF_BIAS,
    parameter int unsigned QBITS = HALF_QBITS
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    output logic [15:0] c,
    output logic        div_zero
);

    div_state_t       state_q;
    logic             sign_q;
    logic signed [6:0] e_q;
    logic             za_q;
    logic             zb_q;
    half_t            c_q;
    logic             div_zero_q;
    logic             out_valid_q;

    logic             start;
    logic             done;
    logic [QBITS-1:0] q;

    logic signed [6:0] exp_n;
    logic [9:0]        frac_n;
    half_t             res;
    logic              dz;

    assign in_ready = (state_q == IDLE);
    assign start    = in_ready && in_valid;

    half_mant_div #(.QBITS(QBITS)) u_mant_div (
        .clk     (clk),
        .rstn    (rstn),
        .start_i (start),
        .ma_i    ({1'b1, a[9:0]}),
        .mb_i    ({1'b1, b[9:0]}),
        .q_o     (q),
        .done_o  (done)
    );

`ifdef HALF_DIVIDE_ROUND_EN
    logic [9:0]  frac_t;
    logic        guard;
    logic [10:0] rsum;
`endif

    always_comb begin
        exp_n  = e_q;
        frac_n = '0;
        res    = '0;
        dz     = 1'b0;
`ifdef HALF_DIVIDE_ROUND_EN
        frac_t = '0;
        guard  = 1'b0;
        if (q[12]) begin
            frac_t = q[11:2];
            guard  = q[1];
        end else begin
            frac_t = q[10:1];
            guard  = q[0];
            exp_n  = e_q - 7'sd1;
        end
        // A carry out of the fraction leaves frac at zero and bumps the exponent,
        // which is then re-checked against the saturation limits below.
        rsum   = {1'b0, frac_t} + {10'd0, guard};
        frac_n = rsum[9:0];
        if (rsum[10]) exp_n = exp_n + 7'sd1;
`else
        if (q[11]) begin
            frac_n = q[10:1];
        end else begin
            frac_n = q[9:0];
            exp_n  = e_q - 7'sd1;
        end
`endif
        if (zb_q) begin
            res = {sign_q, HALF_MAG_SAT};
            dz  = 1'b1;
        end else if (za_q) begin
            res = {sign_q, 15'h0000};
        end else if (exp_n <= 7'sd0) begin
            res = {sign_q, 15'h0000};
        end else if (exp_n >= 7'sd31) begin
            res = {sign_q, HALF_MAG_SAT};
        end else begin
            res = {sign_q, exp_n[4:0], frac_n};
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            e_q         <= '0;
            za_q        <= 1'b0;
            zb_q        <= 1'b0;
            c_q         <= '0;
            div_zero_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    out_valid_q <= 1'b0;
                    if (in_valid) begin
                        sign_q  <= a[15] ^ b[15];
                        e_q     <= $signed({2'b00, a[14:10]}) + $signed(7'(BIAS))
                                 - $signed({2'b00, b[14:10]});
                        za_q    <= (a[14:0] == 15'h0000);
                        zb_q    <= (b[14:0] == 15'h0000);
                        state_q <= DIV;
                    end
                end
                DIV: begin
                    if (done) state_q <= NORM;
                end
                NORM: begin
                    c_q         <= res;
                    div_zero_q  <= dz;
                    out_valid_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign c         = c_q;
    assign div_zero  = div_zero_q;
    assign out_valid = out_valid_q;

endmodule
